// File: rtl/cpu_6502_status_unit.sv
// 6502 processor status register with IRQ/NMI pin synchronisation and interrupt polling.
// Define CPU_6502_CMOS_FLAGS_EN to make interrupt entry also clear D (65C02 behaviour).
module cpu_6502_status_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_alu_valid,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_carry,
  input  logic       i_alu_overflow,
  input  logic [3:0] i_flag_mask,
  input  logic       i_bit_valid,
  input  logic [7:0] i_bit_mem,
  input  logic       i_set_valid,
  input  logic [1:0] i_set_sel,
  input  logic       i_set_value,
  input  logic       i_pull_valid,
  input  logic [7:0] i_pull_data,
  input  logic       i_push_brk,
  input  logic       i_irq_entry,
  input  logic       i_instr_done,
  input  logic       i_nmi_ack,
  input  logic       i_irq_n,
  input  logic       i_nmi_n,
  output logic [7:0] o_p,
  output logic [7:0] o_push_data,
  output logic       o_carry,
  output logic       o_decimal,
  output logic       o_irq_pending,
  output logic       o_nmi_pending
);

  localparam int LAST = SYNC_STAGES - 1;

  logic flag_n_q, flag_v_q, flag_d_q, flag_i_q, flag_z_q, flag_c_q;
  logic flag_n_d, flag_v_d, flag_d_d, flag_i_d, flag_z_d, flag_c_d;
  logic poll_mask_q, poll_mask_d;
  logic irq_pending_q, irq_pending_d;
  logic nmi_latch_q, nmi_latch_d;
  logic nmi_last_q;
  logic [SYNC_STAGES-1:0] irq_sync_q, nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq_sync_d, nmi_sync_d;
  logic nmi_edge;
  logic result_zero;

  assign result_zero = (i_alu_result == 8'h00);
  assign irq_sync_d  = {irq_sync_q[SYNC_STAGES-2:0], i_irq_n};
  assign nmi_sync_d  = {nmi_sync_q[SYNC_STAGES-2:0], i_nmi_n};
  assign nmi_edge    = ~nmi_sync_q[LAST] & nmi_last_q;

  always_comb begin
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    flag_d_d = flag_d_q;
    flag_i_d = flag_i_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    // Only the highest-priority source writes; lower ones are dropped entirely.
    if (i_pull_valid) begin
      flag_n_d = i_pull_data[7];
      flag_v_d = i_pull_data[6];
      flag_d_d = i_pull_data[3];
      flag_i_d = i_pull_data[2];
      flag_z_d = i_pull_data[1];
      flag_c_d = i_pull_data[0];
    end else if (i_set_valid) begin
      case (i_set_sel)
        2'd0:    flag_c_d = i_set_value;
        2'd1:    flag_i_d = i_set_value;
        2'd2:    flag_d_d = i_set_value;
        default: flag_v_d = i_set_value;
      endcase
    end else if (i_bit_valid) begin
      flag_n_d = i_bit_mem[7];
      flag_v_d = i_bit_mem[6];
      flag_z_d = result_zero;
    end else if (i_alu_valid) begin
      if (i_flag_mask[3]) flag_n_d = i_alu_result[7];
      if (i_flag_mask[2]) flag_v_d = i_alu_overflow;
      if (i_flag_mask[1]) flag_z_d = result_zero;
      if (i_flag_mask[0]) flag_c_d = i_alu_carry;
    end
    if (i_irq_entry) begin
      flag_i_d = 1'b1;
`ifdef CPU_6502_CMOS_FLAGS_EN
      flag_d_d = 1'b0;
`else
      flag_d_d = flag_d_d;
`endif
    end
  end

  always_comb begin
    poll_mask_d   = i_instr_done ? flag_i_d : poll_mask_q;
    irq_pending_d = irq_pending_q;
    // The old poll mask is used so an I change takes effect one instruction late.
    if (i_irq_entry)
      irq_pending_d = 1'b0;
    else if (i_instr_done)
      irq_pending_d = ~irq_sync_q[LAST] & ~poll_mask_q;
    nmi_latch_d = nmi_edge | (nmi_latch_q & ~i_nmi_ack);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flag_n_q      <= 1'b0;
      flag_v_q      <= 1'b0;
      flag_d_q      <= 1'b0;
      flag_i_q      <= 1'b1;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      poll_mask_q   <= 1'b1;
      irq_pending_q <= 1'b0;
      nmi_latch_q   <= 1'b0;
      nmi_last_q    <= 1'b1;
      irq_sync_q    <= '1;
      nmi_sync_q    <= '1;
    end else begin
      flag_n_q      <= flag_n_d;
      flag_v_q      <= flag_v_d;
      flag_d_q      <= flag_d_d;
      flag_i_q      <= flag_i_d;
      flag_z_q      <= flag_z_d;
      flag_c_q      <= flag_c_d;
      poll_mask_q   <= poll_mask_d;
      irq_pending_q <= irq_pending_d;
      nmi_latch_q   <= nmi_latch_d;
      nmi_last_q    <= nmi_sync_q[LAST];
      irq_sync_q    <= irq_sync_d;
      nmi_sync_q    <= nmi_sync_d;
    end
  end

  assign o_p           = {flag_n_q, flag_v_q, 1'b1, 1'b1, flag_d_q, flag_i_q, flag_z_q, flag_c_q};
  assign o_push_data   = {flag_n_q, flag_v_q, 1'b1, i_push_brk, flag_d_q, flag_i_q, flag_z_q, flag_c_q};
  assign o_carry       = flag_c_q;
  assign o_decimal     = flag_d_q;
  assign o_irq_pending = irq_pending_q;
  assign o_nmi_pending = nmi_latch_q;

endmodule
